// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the counter scheduler: FSM state encoding,
// default sizing and the round-robin requester pick.
package counter_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First asserted request searching upward from ptr+1, modulo n (n <= 8).
    function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        pick_t r;
        int    k;
        r.valid = 1'b0;
        r.idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            k = (int'(ptr) + i) % n;
            if (i <= n && !r.valid && req[k]) begin
                r.valid = 1'b1;
                r.idx   = 3'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_sched_counter.sv
// Shared up-counter datapath; clear has priority over enable.
module sched_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin arbiter lending one shared up-counter to NREQ requesters,
// each counting from zero to its own limit latched at grant time.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] limit,
    output logic [NREQ-1:0]       grant,
    output logic [2:0]            owner,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic [NREQ-1:0]       done,
    output logic [NREQ-1:0]       aborted
);

    state_t           state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic [WIDTH-1:0] lim_reg, lim_next;
    logic [NREQ-1:0]  grant_reg, grant_next;
    logic [2:0]       owner_reg, owner_next;
    logic [NREQ-1:0]  done_reg, done_next;
    logic [NREQ-1:0]  aborted_reg, aborted_next;
    logic             busy_reg, busy_next;
    logic [7:0]       req_ext;
    logic             owner_req;
    logic             clr, en;
    pick_t            pick;

    sched_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (en),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            ptr_reg     <= 3'(NREQ - 1);
            lim_reg     <= '0;
            grant_reg   <= '0;
            owner_reg   <= '0;
            done_reg    <= '0;
            aborted_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            lim_reg     <= lim_next;
            grant_reg   <= grant_next;
            owner_reg   <= owner_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        owner_req           = req_ext[owner_reg];
        pick                = rr_pick(req_ext, ptr_reg, NREQ);
        state_next          = state_reg;
        ptr_next            = ptr_reg;
        lim_next            = lim_reg;
        grant_next          = grant_reg;
        owner_next          = owner_reg;
        done_next           = '0;
        aborted_next        = '0;
        clr                 = 1'b0;
        en                  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick.valid) begin
                    state_next = CLEAR;
                    lim_next   = limit[int'(pick.idx)*WIDTH +: WIDTH];
                    grant_next = NREQ'(1) << pick.idx;
                    owner_next = pick.idx;
                end
            end
            CLEAR, RUN: begin
                // A dropped owner request cancels the run and freezes the counter.
                if (!owner_req) begin
                    state_next   = IDLE;
                    aborted_next = grant_reg;
                    ptr_next     = owner_reg;
                    grant_next   = '0;
                    owner_next   = '0;
                end else if (state_reg == CLEAR) begin
                    clr        = 1'b1;
                    state_next = RUN;
                end else if (count == lim_reg) begin
                    state_next = DONE;
                    done_next  = grant_reg;
                end else begin
                    en = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                ptr_next   = owner_reg;
                grant_next = '0;
                owner_next = '0;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    assign grant   = grant_reg;
    assign owner   = owner_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;
    assign busy    = busy_reg;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: per-cycle checks against hand-derived
// grant/count/done/aborted sequences.
module tb_counter_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] limit = '0;
    logic [3:0]  grant;
    logic [2:0]  owner;
    logic [7:0]  count;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  aborted;

    int total = 0;
    int bad = 0;

    counter_sched #(.NREQ(4), .WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .limit   (limit),
        .grant   (grant),
        .owner   (owner),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        limit = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        total++;
        if (grant !== 4'b0 || owner !== 3'd0 || count !== 8'd0 || busy !== 1'b0 ||
            done !== 4'b0 || aborted !== 4'b0) begin
            bad++;
            $display("FAIL reset_hold: grant=%b owner=%0d count=%0d busy=%b done=%b aborted=%b, want all 0",
                     grant, owner, count, busy, done, aborted);
        end
        req   = '0;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: grant=%b busy=%b, want 0000/0", grant, busy);
        end
        $display("reset: checked");
    endtask

    task automatic test_single();
        logic [3:0] eg;
        logic [7:0] ec;
        logic [3:0] ed;
        limit[7:0] = 8'd5;
        req = 4'b0001;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            eg = (c <= 7) ? 4'b0001 : 4'b0000;
            ec = (c == 0) ? 8'd0 : ((c - 1 > 5) ? 8'd5 : 8'(c - 1));
            ed = (c == 7) ? 4'b0001 : 4'b0000;
            total++;
            if (grant !== eg || count !== ec || done !== ed || busy !== (c <= 7) || owner !== 3'd0) begin
                bad++;
                $display("FAIL single c=%0d: grant=%b count=%0d done=%b busy=%b owner=%0d, want %b %0d %b %b 0",
                         c, grant, count, done, busy, owner, eg, ec, ed, (c <= 7));
            end
            if (c == 7) req = 4'b0000;
        end
        $display("single: limit 5 run checked");
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic [3:0] ed;
        logic [2:0] eo;
        limit = {8'd2, 8'd2, 8'd2, 8'd2};
        req   = 4'b1111;
        for (int c = 0; c <= 29; c++) begin
            @(negedge clk);
            eg = (c % 6 < 5 && c < 29) ? (4'b0001 << ((c / 6) % 4)) : 4'b0000;
            eo = (c % 6 < 5 && c < 29) ? 3'((c / 6) % 4) : 3'd0;
            ed = (c % 6 == 4) ? eg : 4'b0000;
            total++;
            if (grant !== eg || owner !== eo || done !== ed) begin
                bad++;
                $display("FAIL round_robin c=%0d: grant=%b owner=%0d done=%b, want %b %0d %b",
                         c, grant, owner, done, eg, eo, ed);
            end
            if (c == 28) req = 4'b0000;
        end
        $display("round_robin: five runs checked");
    endtask

    task automatic test_limits();
        int gcycles;
        int done_at;
        int maxc;
        // zero limit: three grant cycles
        limit[15:8] = 8'd0;
        req = 4'b0010;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (grant !== ((c <= 2) ? 4'b0010 : 4'b0000) || done !== ((c == 2) ? 4'b0010 : 4'b0000) ||
                (c >= 1 && count !== 8'd0)) begin
                bad++;
                $display("FAIL limit0 c=%0d: grant=%b done=%b count=%0d", c, grant, done, count);
            end
            if (c == 2) req = 4'b0000;
        end
        // full-scale limit: count saturates at 255, no wrap
        limit[15:8] = 8'd255;
        req = 4'b0010;
        gcycles = 0;
        done_at = -1;
        maxc = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (grant == 4'b0010) gcycles++;
            if (int'(count) > maxc) maxc = int'(count);
            if (done == 4'b0010) begin
                done_at = c;
                req = 4'b0000;
            end
            if (c > 0 && grant == 4'b0000) break;
        end
        total++;
        if (gcycles != 258 || done_at != 257) begin
            bad++;
            $display("FAIL limit255_timing: grant_cycles=%0d done_at=%0d, want 258 257", gcycles, done_at);
        end
        total++;
        if (count !== 8'd255 || maxc != 255) begin
            bad++;
            $display("FAIL limit255_hold: count=%0d max=%0d, want 255 255", count, maxc);
        end
        $display("limits: 0 and 255 checked");
    endtask

    task automatic test_abort();
        int n;
        apply_reset();
        limit = {8'd1, 8'd10, 8'd0, 8'd0};
        req = 4'b1100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(grant == 4'b0100 && count == 8'd3) && n < 30);
        total++;
        if (n >= 30) begin
            bad++;
            $display("FAIL abort_wait: grant=%b count=%0d, want 0100 with count 3", grant, count);
        end
        req = 4'b1000;
        @(negedge clk);
        total++;
        if (aborted !== 4'b0100 || grant !== 4'b0000 || count !== 8'd3 || busy !== 1'b0 || done !== 4'b0) begin
            bad++;
            $display("FAIL abort_pulse: aborted=%b grant=%b count=%0d busy=%b done=%b, want 0100 0000 3 0 0000",
                     aborted, grant, count, busy, done);
        end
        @(negedge clk);
        total++;
        if (aborted !== 4'b0000 || grant !== 4'b1000 || owner !== 3'd3) begin
            bad++;
            $display("FAIL abort_next: aborted=%b grant=%b owner=%0d, want 0000 1000 3", aborted, grant, owner);
        end
        n = 0;
        while (done != 4'b1000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 4'b1000 || count !== 8'd1) begin
            bad++;
            $display("FAIL abort_follow: done=%b count=%0d, want 1000 1", done, count);
        end
        req = 4'b0000;
        @(negedge clk);
        $display("abort: owner 2 cancelled, owner 3 served");
    endtask

    task automatic test_reset_midrun();
        int n;
        apply_reset();
        limit[7:0] = 8'd20;
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (count != 8'd7 && n < 30);
        reset = 1'b1;
        req = 4'b1010;
        #1;
        total++;
        if (grant !== 4'b0 || owner !== 3'd0 || count !== 8'd0 || busy !== 1'b0 ||
            done !== 4'b0 || aborted !== 4'b0) begin
            bad++;
            $display("FAIL reset_midrun: grant=%b owner=%0d count=%0d busy=%b done=%b aborted=%b, want all 0",
                     grant, owner, count, busy, done, aborted);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010 || owner !== 3'd1) begin
            bad++;
            $display("FAIL reset_first_grant: grant=%b owner=%0d, want 0010 1", grant, owner);
        end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        $display("reset_midrun: checked");
    endtask

    task automatic test_limit_change();
        apply_reset();
        limit[7:0] = 8'd5;
        req = 4'b0001;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) limit[7:0] = 8'd9;
            if (c == 7 || c == 8) begin
                total++;
                if (done !== ((c == 7) ? 4'b0001 : 4'b0000) || count !== 8'd5 ||
                    grant !== ((c == 7) ? 4'b0001 : 4'b0000)) begin
                    bad++;
                    $display("FAIL limit_change c=%0d: done=%b count=%0d grant=%b, want count 5",
                             c, done, count, grant);
                end
            end
            if (c == 7) req = 4'b0000;
        end
        $display("limit_change: latched limit checked");
    endtask

    initial begin
        test_reset();
        test_single();
        apply_reset();
        test_round_robin();
        test_limits();
        test_abort();
        test_reset_midrun();
        test_limit_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one 8-bit up-counter among NREQ requesters. Each requester asks for a counting run to a programmed limit. The block grants the counter to one requester at a time, clears it, counts to the limit, and signals completion. It sits between the client blocks and the shared counter datapath, and is the only agent that clears or advances the counter.

## Interface
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: counter and limit width
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request level; held high until done or abort
- limit  in  NREQ*WIDTH  per-requester terminal count; slice i is limit[i*WIDTH +: WIDTH]
- grant  out  NREQ  one-hot owner of the counter; all zero when idle
- owner  out  3  binary index of the granted requester; 0 when idle
- count  out  WIDTH  current counter value
- busy  out  1  high in CLEAR, RUN and DONE
- done  out  NREQ  one-cycle pulse to the owner when count reaches its limit
- aborted  out  NREQ  one-cycle pulse to the owner when its run is cancelled

## Operation
- State machine: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If req is nonzero, select the first requester whose req is high, searching from index ptr+1 upward modulo NREQ.
  - Latch that requester's limit slice into lim_q, set grant and owner, and go to CLEAR.
  - If req is zero, stay in IDLE.
- CLEAR: count <= 0, then go to RUN.
- RUN:
  - If count == lim_q, go to DONE and hold count.
  - Otherwise count <= count + 1.
  - Arithmetic is unsigned WIDTH-bit. Count never wraps, because it stops at lim_q ≤ 2^WIDTH−1.
- DONE:
  - done[owner] is high for exactly this cycle.
  - Next edge: ptr <= owner, grant and owner clear, go to IDLE.
- Abort: if req[owner] drops while in CLEAR or RUN:
  - Pulse aborted[owner] for one cycle.
  - Update ptr <= owner, clear grant, and return to IDLE.
  - count holds its last value.
- A drop of req[owner] in DONE is ignored; the run counts as completed.
- Changes to limit after grant are ignored, because lim_q is latched at grant.
- Requests from non-owners are held pending. They have no effect until IDLE.
- If the owner keeps req high after DONE, it is treated as a new request. Round-robin then favours every other pending requester before it.
- Reset values:
  - state = IDLE, ptr = NREQ−1 (so requester 0 wins first).
  - grant, done, aborted = 0; owner = 0; count = 0; busy = 0; lim_q = 0.
- Reset mid-run: immediate return to the reset values. No done or aborted pulse is issued.

## Timing
- All outputs are registered; there is no combinational path from req or limit to any output.
- Request sampled at edge E: grant is visible after E, CLEAR after E, count = 0 after E+1.
- count = k after edge E+1+k.
- For limit L: DONE (done pulse) after edge E+2+L, and IDLE with grant low after E+3+L. Grant is high for L+3 cycles.
- Limit 0: count=0 in RUN immediately matches, so the run takes 3 grant cycles.
- Back-to-back: the next grant is issued at the edge after returning to IDLE. There is one IDLE cycle between runs.
- Abort: if req[owner] is low at edge A, aborted is high and grant low after A. The pulse lasts one cycle.

## Structure
- Shared package `counter_sched_pkg`:
  - State enum (IDLE, CLEAR, RUN, DONE).
  - Default NREQ/WIDTH constants.
  - Function for the round-robin pick: (req, ptr) -> index and valid.
- Sub-module `sched_counter`: WIDTH-bit counter with clr and en inputs and async active-high reset. The FSM drives clr in CLEAR and en in RUN when count != lim_q.
- The top level contains the FSM, ptr, lim_q and output registers.

## Test plan
- Reset, then req=4'b0001 with limit0=5: grant=0001 for 8 cycles, count steps 0..5, done=0001 for one cycle, then grant=0 and count holds 5.
- req=4'b1111 held continuously, all limits=2: grants in order 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between runs and each run 5 cycles.
- limit1=0 and limit1=255: the zero-limit run completes in 3 grant cycles; the 255-limit run reaches count=255, stops without wrap, and done fires after 258 grant cycles.
- Owner 2 drops req when count=3: aborted=0100 pulses one cycle, grant clears, and the pending requester 3 is granted next.
- Assert reset when count=7 during a run: all outputs are 0 immediately; after reset release with req=4'b1010, requester 1 is granted first.
- Change limit0 from 5 to 9 after grant: the run still ends at count=5.
